// File: rtl/sfp_ctrl.sv
// Sequencer for the accumulate-and-ReLU stage: walks the psum SRAM kij-inner / nij-outer,
// drives accumulator strobes and the output write 3 cycles behind each pixel's last read.
module sfp_ctrl #(
   parameter int AW = 11,
   parameter int NW = 8,
   parameter int KW = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [NW-1:0] cfg_nij,
   input  logic [KW-1:0] cfg_kij,
   input  logic          stall,
   output logic          rd_en,
   output logic [AW-1:0] rd_addr,
   output logic          acc_en,
   output logic          acc_clr,
   output logic          wr_en,
   output logic [NW-1:0] wr_addr,
   output logic          busy,
   output logic          done
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t                 state_q, state_d;
   logic [NW-1:0]          nij_cfg_q, nij_cfg_d;
   logic [KW-1:0]          kij_cfg_q, kij_cfg_d;
   logic [NW-1:0]          nij_q, nij_d;
   logic [KW-1:0]          kij_q, kij_d;
   logic [AW-1:0]          addr_q, addr_d;
   logic                   rd_en_q, rd_en_d;
   logic                   acc_en_q, acc_en_d;
   logic                   acc_clr_q, acc_clr_d;
   logic [2:0]             vld_pipe_q, vld_pipe_d;
   logic [2:0][NW-1:0]     adr_pipe_q, adr_pipe_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;

   logic [NW-1:0]          nij_last;
   logic [KW-1:0]          kij_last;
   logic                   last_rd;

   assign nij_last = nij_cfg_q - NW'(1);
   assign kij_last = kij_cfg_q - KW'(1);
   assign last_rd  = (nij_q == nij_last) && (kij_q == kij_last);

   // Counters always name the most recently issued read; a non-stalled RUN edge
   // advances from it, a stalled edge leaves it in place.
   always_comb begin
      state_d   = state_q;
      nij_cfg_d = nij_cfg_q;
      kij_cfg_d = kij_cfg_q;
      nij_d     = nij_q;
      kij_d     = kij_q;
      addr_d    = addr_q;
      rd_en_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (cfg_nij != '0 && cfg_kij != '0) begin
                  state_d   = RUN;
                  nij_cfg_d = cfg_nij;
                  kij_cfg_d = cfg_kij;
                  nij_d     = '0;
                  kij_d     = '0;
                  addr_d    = '0;
                  rd_en_d   = 1'b1;
               end else begin
                  state_d = DONE;
               end
            end
         end
         RUN: begin
            if (last_rd) begin
               state_d = DRAIN;
            end else if (!stall) begin
               rd_en_d = 1'b1;
               if (kij_q == kij_last) begin
                  kij_d  = '0;
                  nij_d  = nij_q + NW'(1);
                  addr_d = AW'(nij_q) + AW'(1);
               end else begin
                  kij_d  = kij_q + KW'(1);
                  addr_d = addr_q + AW'(nij_cfg_q);
               end
            end
         end
         DRAIN: begin
            if (vld_pipe_q[2] && vld_pipe_q[1:0] == 2'b00) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      acc_en_d   = rd_en_q;
      acc_clr_d  = rd_en_q && (kij_q == '0);
      vld_pipe_d = {vld_pipe_q[1:0], rd_en_q && (kij_q == kij_last)};
      adr_pipe_d = {adr_pipe_q[1:0], nij_q};
      busy_d     = (state_d == RUN) || (state_d == DRAIN);
      done_d     = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         nij_cfg_q  <= '0;
         kij_cfg_q  <= '0;
         nij_q      <= '0;
         kij_q      <= '0;
         addr_q     <= '0;
         rd_en_q    <= 1'b0;
         acc_en_q   <= 1'b0;
         acc_clr_q  <= 1'b0;
         vld_pipe_q <= '0;
         adr_pipe_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         nij_cfg_q  <= nij_cfg_d;
         kij_cfg_q  <= kij_cfg_d;
         nij_q      <= nij_d;
         kij_q      <= kij_d;
         addr_q     <= addr_d;
         rd_en_q    <= rd_en_d;
         acc_en_q   <= acc_en_d;
         acc_clr_q  <= acc_clr_d;
         vld_pipe_q <= vld_pipe_d;
         adr_pipe_q <= adr_pipe_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign rd_en   = rd_en_q;
   assign rd_addr = addr_q;
   assign acc_en  = acc_en_q;
   assign acc_clr = acc_clr_q;
   assign wr_en   = vld_pipe_q[2];
   assign wr_addr = adr_pipe_q[2];
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_sfp_ctrl.sv
// Directed bench for sfp_ctrl: per-cycle capture of all outputs, compared against
// hand-written event tables relative to the start cycle.
module tb_sfp_ctrl;
   localparam int AW = 11;
   localparam int NW = 8;
   localparam int KW = 4;
   localparam int MAXC = 2100;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          stall = 1'b0;
   logic [NW-1:0] cfg_nij = '0;
   logic [KW-1:0] cfg_kij = '0;
   logic          rd_en, acc_en, acc_clr, wr_en, busy, done;
   logic [AW-1:0] rd_addr;
   logic [NW-1:0] wr_addr;

   sfp_ctrl #(.AW(AW), .NW(NW), .KW(KW)) dut (
      .clk(clk), .reset(reset), .start(start), .cfg_nij(cfg_nij), .cfg_kij(cfg_kij),
      .stall(stall), .rd_en(rd_en), .rd_addr(rd_addr), .acc_en(acc_en), .acc_clr(acc_clr),
      .wr_en(wr_en), .wr_addr(wr_addr), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int o_rd[MAXC], o_addr[MAXC], o_acc[MAXC], o_clr[MAXC], o_wr[MAXC], o_wad[MAXC], o_busy[MAXC], o_done[MAXC];
   int e_rd[MAXC], e_addr[MAXC], e_acc[MAXC], e_clr[MAXC], e_wr[MAXC], e_wad[MAXC], e_busy[MAXC], e_done[MAXC];

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic sample(input int c);
      o_rd[c] = int'(rd_en);   o_addr[c] = int'(rd_addr);
      o_acc[c] = int'(acc_en); o_clr[c] = int'(acc_clr);
      o_wr[c] = int'(wr_en);   o_wad[c] = int'(wr_addr);
      o_busy[c] = int'(busy);  o_done[c] = int'(done);
   endtask

   // Cycle c: sample at its negedge, then drive that cycle's inputs.
   task automatic run(input int n, input int k, input int stall_c, input int restart_c, input int ncyc);
      cfg_nij = NW'(n);
      cfg_kij = KW'(k);
      for (int c = 0; c <= ncyc; c++) begin
         @(negedge clk);
         sample(c);
         start = (c == 0) || (c == restart_c);
         stall = (c == stall_c);
      end
   endtask

   task automatic exp_clear();
      for (int c = 0; c < MAXC; c++) begin
         e_rd[c] = 0; e_addr[c] = 0; e_acc[c] = 0; e_clr[c] = 0;
         e_wr[c] = 0; e_wad[c] = 0; e_busy[c] = 0; e_done[c] = 0;
      end
   endtask

   task automatic exp_rd(input int c, input int a);   e_rd[c] = 1; e_addr[c] = a; endtask
   task automatic exp_wr(input int c, input int a);   e_wr[c] = 1; e_wad[c] = a;  endtask
   task automatic exp_acc(input int lo, input int hi);  for (int c = lo; c <= hi; c++) e_acc[c] = 1;  endtask
   task automatic exp_busy(input int lo, input int hi); for (int c = lo; c <= hi; c++) e_busy[c] = 1; endtask

   task automatic cmp_all(input string nm, input int ncyc);
      for (int c = 0; c <= ncyc; c++) begin
         chk($sformatf("%s rd_en c%0d", nm, c), o_rd[c], e_rd[c]);
         if (e_rd[c] != 0) chk($sformatf("%s rd_addr c%0d", nm, c), o_addr[c], e_addr[c]);
         chk($sformatf("%s acc_en c%0d", nm, c), o_acc[c], e_acc[c]);
         chk($sformatf("%s acc_clr c%0d", nm, c), o_clr[c], e_clr[c]);
         chk($sformatf("%s wr_en c%0d", nm, c), o_wr[c], e_wr[c]);
         if (e_wr[c] != 0) chk($sformatf("%s wr_addr c%0d", nm, c), o_wad[c], e_wad[c]);
         chk($sformatf("%s busy c%0d", nm, c), o_busy[c], e_busy[c]);
         chk($sformatf("%s done c%0d", nm, c), o_done[c], e_done[c]);
      end
   endtask

   task automatic exp_basic();
      exp_clear();
      exp_rd(1, 0); exp_rd(2, 2); exp_rd(3, 4); exp_rd(4, 1); exp_rd(5, 3); exp_rd(6, 5);
      exp_acc(2, 7); e_clr[2] = 1; e_clr[5] = 1;
      exp_wr(6, 0); exp_wr(9, 1);
      exp_busy(1, 9); e_done[10] = 1;
   endtask

   task automatic chk_outs_zero(input string nm);
      chk({nm, " rd_en"}, int'(rd_en), 0);     chk({nm, " rd_addr"}, int'(rd_addr), 0);
      chk({nm, " acc_en"}, int'(acc_en), 0);   chk({nm, " acc_clr"}, int'(acc_clr), 0);
      chk({nm, " wr_en"}, int'(wr_en), 0);     chk({nm, " wr_addr"}, int'(wr_addr), 0);
      chk({nm, " busy"}, int'(busy), 0);       chk({nm, " done"}, int'(done), 0);
   endtask

   initial begin
      #2 reset = 1'b0;
      @(negedge clk);
      chk_outs_zero("reset");
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // Basic pass
      run(2, 3, -1, -1, 12);
      exp_basic();
      cmp_all("basic", 12);

      // Stall seen in cycle 3 removes the read of cycle 4; later events slip by one
      run(2, 3, 3, -1, 13);
      exp_clear();
      exp_rd(1, 0); exp_rd(2, 2); exp_rd(3, 4); exp_rd(5, 1); exp_rd(6, 3); exp_rd(7, 5);
      exp_acc(2, 4); exp_acc(6, 8); e_clr[2] = 1; e_clr[6] = 1;
      exp_wr(6, 0); exp_wr(10, 1);
      exp_busy(1, 10); e_done[11] = 1;
      cmp_all("stall", 13);

      // kij=1: every pixel is load-and-write
      run(4, 1, -1, -1, 10);
      exp_clear();
      for (int i = 0; i < 4; i++) begin
         exp_rd(1 + i, i);
         e_clr[2 + i] = 1;
         exp_wr(4 + i, i);
      end
      exp_acc(2, 5); exp_busy(1, 7); e_done[8] = 1;
      cmp_all("k1", 10);

      // Zero configs go straight to done
      run(0, 3, -1, -1, 4);
      exp_clear(); e_done[1] = 1;
      cmp_all("nij0", 4);
      run(3, 0, -1, -1, 4);
      cmp_all("kij0", 4);

      // Start during RUN is ignored
      run(2, 3, -1, 3, 12);
      exp_basic();
      cmp_all("restart", 12);

      // Reset in cycle 4 of a basic pass
      cfg_nij = 8'd2; cfg_kij = 4'd3;
      for (int c = 0; c <= 3; c++) begin
         @(negedge clk);
         start = (c == 0);
      end
      @(negedge clk);
      chk("mid pre rd_en", int'(rd_en), 1);
      chk("mid pre rd_addr", int'(rd_addr), 1);
      reset = 1'b0;
      #1;
      chk_outs_zero("mid reset");
      @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk($sformatf("post wr_en %0d", c), int'(wr_en), 0);
         chk($sformatf("post done %0d", c), int'(done), 0);
         chk($sformatf("post rd_en %0d", c), int'(rd_en), 0);
      end
      run(2, 3, -1, -1, 12);
      exp_basic();
      cmp_all("after_rst", 12);

      // Full-width addressing
      run(255, 8, -1, -1, 2046);
      chk("full addr c2", o_addr[2], 255);
      chk("full addr c9", o_addr[9], 1);
      chk("full rd c2040", o_rd[2040], 1);
      chk("full addr c2040", o_addr[2040], 2039);
      chk("full rd c2041", o_rd[2041], 0);
      chk("full wr c2043", o_wr[2043], 1);
      chk("full wad c2043", o_wad[2043], 254);
      chk("full busy c2043", o_busy[2043], 1);
      chk("full done c2043", o_done[2043], 0);
      chk("full done c2044", o_done[2044], 1);
      chk("full busy c2044", o_busy[2044], 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
